// File: rtl/axis_1553_pkg.sv
// Shared definitions for the MIL-STD-1553 Manchester encoder: line codes,
// sync patterns, word length and encoder states.
package axis_1553_pkg;

    localparam logic [1:0] DIFF_POS  = 2'b10;
    localparam logic [1:0] DIFF_NEG  = 2'b01;
    localparam logic [1:0] DIFF_IDLE = 2'b00;

    // One word on the line: 6 sync + 32 data + 2 parity half-bits
    localparam int WORD_HB = 40;

    // Half-bit patterns, MSB goes out first; 1 = positive, 0 = negative
    localparam logic [5:0] SYNC_CMD  = 6'b111000;
    localparam logic [5:0] SYNC_DATA = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_TX
    } state_e;

    // Expand a payload into its 40 half-bit line pattern (MSB first).
    // Each bit becomes {b, ~b}; parity makes the count of ones odd.
    function automatic logic [WORD_HB-1:0] build_word(input logic [15:0] data,
                                                      input logic        cmd);
        logic [WORD_HB-1:0] w;
        logic               par;
        w        = '0;
        w[39:34] = cmd ? SYNC_CMD : SYNC_DATA;
        for (int i = 0; i < 16; i++) begin
            w[33-2*i] = data[15-i];
            w[32-2*i] = ~data[15-i];
        end
        par  = ~^data;
        w[1] = par;
        w[0] = ~par;
        return w;
    endfunction

endpackage

// File: rtl/axis_1553_fifo.sv
// Word buffer: first-word-fall-through FIFO with occupancy count.
// A push is refused whenever the FIFO is full, even if a pop happens
// in the same cycle.
module axis_1553_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    // Pointer / level update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        full    = (level_q == (AW+1)'(DEPTH));
        empty   = (level_q == '0);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        rdata = mem_q[rptr_q];
        level = level_q;
    end

    // Control state; reset flushes the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array, no reset needed since pointers gate every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/axis_1553_encoder_fifo.sv
// AXI-Stream fed MIL-STD-1553 Manchester encoder with an input word buffer.
// FIFO entry = {tuser, tdata}: tuser[0] selects command sync, tuser[7:1]
// is the idle gap in microseconds before the word.
module axis_1553_encoder_fifo
    import axis_1553_pkg::*;
#(
    parameter int CLOCK_SPEED = 20000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          aclk,
    input  logic                          arst,
    input  logic [15:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic [7:0]                    s_axis_tuser,
    output logic                          s_axis_tready,
    output logic [1:0]                    diff,
    output logic                          en_diff,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          word_done
);
    localparam int H        = CLOCK_SPEED / 2000000;
    localparam int GAP_UNIT = CLOCK_SPEED / 1000000;

    state_e              state_q, state_d;
    logic [WORD_HB-1:0]  shreg_q, shreg_d;
    logic [31:0]         hcnt_q, hcnt_d;
    logic [5:0]          bidx_q, bidx_d;
    logic [31:0]         gcnt_q, gcnt_d;
    logic                ready_q, ready_d;

    logic [23:0]         head;
    logic                fifo_full, fifo_empty, push, pop;
    logic [15:0]         head_data;
    logic                head_cmd;
    logic [6:0]          head_gap;
    logic                half_end;

    assign head_data     = head[15:0];
    assign head_cmd      = head[16];
    assign head_gap      = head[23:17];
    assign s_axis_tready = ready_q & ~fifo_full;
    assign push          = s_axis_tvalid & s_axis_tready;

    axis_1553_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk   (aclk),
        .rst   (arst),
        .push  (push),
        .pop   (pop),
        .wdata ({s_axis_tuser, s_axis_tdata}),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Encoder next-state, shifter and line outputs
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        hcnt_d    = hcnt_q;
        bidx_d    = bidx_q;
        gcnt_d    = gcnt_q;
        ready_d   = 1'b1;
        pop       = 1'b0;
        word_done = 1'b0;
        half_end  = (hcnt_q == 32'(H-1));

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                shreg_d = build_word(head_data, head_cmd);
                hcnt_d  = '0;
                bidx_d  = '0;
                if (head_gap != 7'd0) begin
                    // LOAD itself is the first idle cycle of the gap, and
                    // GAP lasts gcnt+1 cycles, hence the -2
                    gcnt_d  = 32'(head_gap) * 32'(GAP_UNIT) - 32'd2;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_GAP: begin
                if (gcnt_q == '0) state_d = ST_TX;
                else              gcnt_d  = gcnt_q - 32'd1;
            end
            ST_TX: begin
                if (!half_end) begin
                    hcnt_d = hcnt_q + 32'd1;
                end else begin
                    hcnt_d = '0;
                    if (bidx_q == 6'(WORD_HB-1)) begin
                        word_done = 1'b1;
                        if (!fifo_empty && head_gap == 7'd0) begin
                            // back-to-back word: reload without leaving TX
                            pop     = 1'b1;
                            shreg_d = build_word(head_data, head_cmd);
                            bidx_d  = '0;
                        end else if (!fifo_empty) begin
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bidx_d  = bidx_q + 6'd1;
                        shreg_d = {shreg_q[WORD_HB-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_diff = (state_q == ST_TX);
        diff    = en_diff ? (shreg_q[WORD_HB-1] ? DIFF_POS : DIFF_NEG) : DIFF_IDLE;
    end

    // State registers; reset aborts any word in flight
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            hcnt_q  <= '0;
            bidx_q  <= '0;
            gcnt_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            hcnt_q  <= hcnt_d;
            bidx_q  <= bidx_d;
            gcnt_q  <= gcnt_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_axis_1553_encoder_fifo.sv
// Scoreboard bench for axis_1553_encoder_fifo at 20 MHz, depth 8.
// Stimulus queues hand-computed expectations; the line monitor decodes each
// transmitted word and checks it against the queue head.
module tb_axis_1553_encoder_fifo;
    localparam int H  = 10;
    localparam int WL = 40 * H;

    logic        aclk = 1'b0;
    logic        arst;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic [7:0]  s_axis_tuser;
    logic        s_axis_tready;
    logic [1:0]  diff;
    logic        en_diff;
    logic [3:0]  fifo_level;
    logic        word_done;

    axis_1553_encoder_fifo #(.CLOCK_SPEED(20000000), .FIFO_DEPTH(8)) dut (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .diff          (diff),
        .en_diff       (en_diff),
        .fifo_level    (fifo_level),
        .word_done     (word_done)
    );

    always #25 aclk = ~aclk;

    typedef struct {
        logic [15:0] data;
        logic        cmd;
        logic        par;
        int          gap;   // expected idle cycles before the word, -1 = any
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wd_cnt = 0;
    int   en_cnt = 0;
    logic saw_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, expv);
        end
    endtask

    // ---------------- line monitor ----------------
    logic [1:0] smp [WL];
    logic       in_word = 1'b0;
    int         cyc = 0;
    int         low_cnt = -1;
    int         gap_seen = -1;
    logic       wd_bad = 1'b0;
    logic       idle_bad = 1'b0;

    task automatic check_word();
        logic [39:0] hb;
        logic [5:0]  sync;
        logic [15:0] data;
        logic        bad_hb, bad_man;
        exp_t        e;
        bad_hb  = 1'b0;
        bad_man = 1'b0;
        sync    = '0;
        data    = '0;
        hb      = '0;
        for (int h = 0; h < 40; h++) begin
            hb[h] = (smp[h*H] == 2'b10);
            if (smp[h*H] !== 2'b10 && smp[h*H] !== 2'b01) bad_hb = 1'b1;
            for (int c = 1; c < H; c++)
                if (smp[h*H+c] !== smp[h*H]) bad_hb = 1'b1;
        end
        for (int i = 0; i < 6; i++) sync = {sync[4:0], hb[i]};
        for (int i = 0; i < 16; i++) begin
            data = {data[14:0], hb[6+2*i]};
            if (hb[6+2*i] == hb[7+2*i]) bad_man = 1'b1;
        end
        if (hb[38] == hb[39]) bad_man = 1'b1;
        if (exp_q.size() == 0) begin
            chk("unexpected word", 32'(data), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("word data", 32'(data), 32'(e.data));
            chk("sync pattern", 32'(sync), e.cmd ? 32'h38 : 32'h07);
            chk("parity", 32'(hb[38]), 32'(e.par));
            chk("half-bit width", 32'(bad_hb), 32'd0);
            chk("manchester pairs", 32'(bad_man), 32'd0);
            chk("word_done timing", 32'(wd_bad), 32'd0);
            chk("idle line quiet", 32'(idle_bad), 32'd0);
            if (e.gap >= 0) chk("inter-word gap", 32'(gap_seen), 32'(e.gap));
        end
        idle_bad = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (arst) begin
            in_word  = 1'b0;
            cyc      = 0;
            low_cnt  = -1;
            idle_bad = 1'b0;
        end else begin
            if (word_done === 1'b1) wd_cnt++;
            if (en_diff === 1'b1) begin
                en_cnt++;
                if (!in_word) begin
                    in_word  = 1'b1;
                    cyc      = 0;
                    gap_seen = low_cnt;
                    wd_bad   = 1'b0;
                end
                smp[cyc] = diff;
                if (word_done !== (cyc == WL-1)) wd_bad = 1'b1;
                cyc++;
                if (cyc == WL) begin
                    check_word();
                    in_word = 1'b0;
                    low_cnt = 0;
                end
            end else begin
                if (in_word) begin
                    chk("truncated word length", 32'(cyc), 32'(WL));
                    in_word = 1'b0;
                end
                if (diff !== 2'b00 || word_done !== 1'b0) idle_bad = 1'b1;
                if (low_cnt >= 0) low_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] d, input logic [7:0] u,
                        input logic par, input int gap);
        int n = 0;
        exp_t e;
        e.data = d; e.cmd = u[0]; e.par = par; e.gap = gap;
        exp_q.push_back(e);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 5000) begin
            if (fifo_level == 4'd8) saw_full = 1'b1;
            @(negedge aclk);
            n++;
        end
        if (n >= 5000) chk("push accept timeout", 32'(n), 32'd0);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || en_diff === 1'b1) && n < bound) begin
            @(negedge aclk);
            n++;
        end
        if (n >= bound) chk("drain timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge aclk);
    endtask

    initial begin
        int wd0, en0, n;
        arst          = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;

        // reset held 100 ns
        #10;
        chk("rst diff", 32'(diff), 32'd0);
        chk("rst en_diff", 32'(en_diff), 32'd0);
        chk("rst tready", 32'(s_axis_tready), 32'd0);
        #80;
        chk("rst tready late", 32'(s_axis_tready), 32'd0);
        chk("rst level", 32'(fifo_level), 32'd0);
        @(negedge aclk);
        #5 arst = 1'b0;
        #1 chk("tready before first edge", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        chk("tready after first edge", 32'(s_axis_tready), 32'd1);

        // single command word 0x0000, plus latency
        wd0 = wd_cnt; en0 = en_cnt;
        push(16'h0000, 8'h01, 1'b1, -1);
        chk("latency k..k+1 en_diff", 32'(en_diff), 32'd0);
        @(negedge aclk);
        chk("latency k+1..k+2 en_diff", 32'(en_diff), 32'd0);
        @(negedge aclk);
        chk("latency k+2 en_diff", 32'(en_diff), 32'd1);
        chk("latency k+2 diff", 32'(diff), 32'h2);
        wait_idle(2000);
        chk("word_done count single", 32'(wd_cnt - wd0), 32'd1);
        chk("en_diff cycles single", 32'(en_cnt - en0), 32'd400);

        // data word 0x0001
        push(16'h0001, 8'h00, 1'b0, -1);
        wait_idle(2000);

        // burst of 10 contiguous data words
        wd0 = wd_cnt; en0 = en_cnt; saw_full = 1'b0;
        push(16'h0000, 8'h00, 1'b1, -1);
        push(16'h0001, 8'h00, 1'b0, 0);
        push(16'hFFFF, 8'h00, 1'b1, 0);
        push(16'h8000, 8'h00, 1'b0, 0);
        push(16'h00FF, 8'h00, 1'b1, 0);
        push(16'h1234, 8'h00, 1'b0, 0);
        push(16'hA5A5, 8'h00, 1'b1, 0);
        push(16'h7FFF, 8'h00, 1'b0, 0);
        push(16'h0003, 8'h00, 1'b1, 0);
        push(16'hC000, 8'h00, 1'b1, 0);
        chk("tready low at level 8", 32'(saw_full), 32'd1);
        wait_idle(6000);
        chk("burst word_done count", 32'(wd_cnt - wd0), 32'd10);
        chk("burst en_diff cycles", 32'(en_cnt - en0), 32'd4000);

        // second word carries a 4 us gap and command sync
        push(16'h1234, 8'h00, 1'b0, -1);
        push(16'h5555, 8'h09, 1'b1, 80);
        wait_idle(3000);

        // reset at cycle 150 of a word with more words queued
        push(16'hFFFF, 8'h00, 1'b1, -1);
        push(16'h00FF, 8'h00, 1'b1, 0);
        push(16'h8000, 8'h00, 1'b0, 0);
        n = 0;
        while (en_diff !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        chk("word start before abort", 32'(en_diff), 32'd1);
        repeat (149) @(negedge aclk);
        #5 arst = 1'b1;
        #1;
        chk("abort diff", 32'(diff), 32'd0);
        chk("abort en_diff", 32'(en_diff), 32'd0);
        chk("abort level", 32'(fifo_level), 32'd0);
        chk("abort tready", 32'(s_axis_tready), 32'd0);
        chk("abort word_done", 32'(word_done), 32'd0);
        exp_q.delete();
        @(negedge aclk);
        #5 arst = 1'b0;
        en0 = en_cnt; wd0 = wd_cnt;
        repeat (1000) @(negedge aclk);
        chk("no activity after abort", 32'(en_cnt - en0), 32'd0);
        chk("no word_done after abort", 32'(wd_cnt - wd0), 32'd0);
        chk("level after abort", 32'(fifo_level), 32'd0);

        // encoder works again after the abort
        push(16'hC000, 8'h01, 1'b1, -1);
        wait_idle(2000);
        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_1553_encoder_fifo.md
AXIS_1553_ENCODER_FIFO -- requirements
Module: axis_1553_encoder_fifo

Interface
REQ-001 Parameter CLOCK_SPEED, default 20000000, aclk frequency in Hz; SHALL be an integer multiple of 2000000.
REQ-002 Parameter FIFO_DEPTH, default 8, word buffer depth; SHALL be a power of two, minimum 2.
REQ-003 aclk  input  1  single clock; all logic is on its rising edge.
REQ-004 arst  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_tdata  input  16  1553 word payload.
REQ-006 s_axis_tvalid  input  1  payload valid.
REQ-007 s_axis_tuser  input  8  bit0 = sync type (1 command/status, 0 data); bits7:1 = gap before word, in µs (0 = contiguous).
REQ-008 s_axis_tready  output  1  FIFO not full.
REQ-009 diff  output  2  Manchester line: 2'b10 positive, 2'b01 negative, 2'b00 idle.
REQ-010 en_diff  output  1  transmitter enable; high only while a word is on the line.
REQ-011 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 word_done  output  1  one-cycle pulse on the last cycle of each transmitted word.

Function
REQ-013 Half-bit period H = CLOCK_SPEED/2000000 cycles (H = 10 at default).
REQ-014 Word = 40 half-bits: sync (6), 16 data bits MSB first (32), odd parity over data (2); en_diff high exactly 40*H cycles per word.
REQ-015 Command/status sync: 3 half-bits positive, then 3 negative; data sync: 3 negative, then 3 positive.
REQ-016 Data/parity bit 1 = positive then negative; bit 0 = negative then positive.
REQ-017 Transfer occurs on a rising edge with tvalid & tready; tdata and tuser are written to the FIFO together.
REQ-018 tready = (fifo_level < FIFO_DEPTH); a simultaneous push and pop while full SHALL NOT be accepted.
REQ-019 States: IDLE, LOAD, GAP, TX.
REQ-020 IDLE -> LOAD when the FIFO is non-empty; LOAD pops one entry and builds the 40-half-bit pattern.
REQ-021 LOAD -> GAP if gap > 0, else -> TX; GAP holds diff = 00 and en_diff = 0 for gap*CLOCK_SPEED/1000000 cycles, then -> TX.
REQ-022 TX end: if FIFO is non-empty and the next gap = 0, the next word's first half-bit follows on the very next cycle, with no en_diff drop (prefetch during the final half-bit); otherwise TX -> LOAD or IDLE.
REQ-023 Latency, empty FIFO and gap 0: word accepted at edge k, popped at edge k+1; diff/en_diff are valid from edge k+2.
REQ-024 Push and pop in the same cycle SHALL leave fifo_level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 word_done SHALL assert once per word, coincident with the final cycle of the parity half-bit.

Reset
REQ-026 arst asserted: diff = 00, en_diff = 0, s_axis_tready = 0, word_done = 0, fifo_level = 0, state = IDLE, FIFO flushed, immediately and without a clock.
REQ-027 First rising edge after arst release: s_axis_tready = 1.
REQ-028 Reset mid-word SHALL abort the word; it SHALL NOT be retransmitted.

Structure
REQ-029 Shared package axis_1553_pkg: diff encodings (POS/NEG/IDLE), sync patterns, word half-bit count (40), state encodings.
REQ-030 The FIFO SHALL be the sub-module axis_1553_fifo (FIFO_DEPTH, width 24); the encoder FSM and shifter stay in the top module.

Verification (CLOCK_SPEED = 20 MHz, FIFO_DEPTH = 8)
REQ-031 arst held 100 ns -> diff = 00, en_diff = 0, tready = 0 throughout; tready = 1 on the first edge after release.
REQ-032 tdata 0x0000, tuser 0x01 -> 30 cycles 10, 30 cycles 01, 16×(10 cycles 01 + 10 cycles 10), parity 1 (10 cycles 10 + 10 cycles 01); en_diff high 400 cycles; word_done once.
REQ-033 tdata 0x0001, tuser 0x00 -> 30 cycles 01, 30 cycles 10, last data bit 10-then-01, parity 0 (01-then-10).
REQ-034 Burst of 10 words, tuser 0x00, tvalid held high -> tready low while level = 8; en_diff continuous for 4000 cycles; 10 word_done pulses; words emitted in input order.
REQ-035 Two words, second with tuser 0x09 -> en_diff low exactly 80 cycles between words; second word uses command sync.
REQ-036 arst pulsed at cycle 150 of a word, with 3 words queued -> outputs idle immediately, fifo_level = 0; no further line activity until a new push.
